// File: rtl/issue_split_if.sv
// Issue-stage bus between the issue buffers, the pair checker and the issue/execute buffers.
// The master side is the pipeline; the slave side is the pair checker.
interface issue_split_if #(
    parameter int unsigned CTRL_W = 16
);
    logic [31:0]       inst0_issue;
    logic [31:0]       inst1_issue;
    logic [CTRL_W-1:0] ctrl0_issue;
    logic [CTRL_W-1:0] ctrl1_issue;
    logic              backend_we;
    logic [31:0]       issued_inst0;
    logic [31:0]       issued_inst1;
    logic [CTRL_W-1:0] issued_ctrl0;
    logic [CTRL_W-1:0] issued_ctrl1;
    logic              split_stall;

    modport master (
        output inst0_issue,
        output inst1_issue,
        output ctrl0_issue,
        output ctrl1_issue,
        output backend_we,
        input  issued_inst0,
        input  issued_inst1,
        input  issued_ctrl0,
        input  issued_ctrl1,
        input  split_stall
    );

    modport slave (
        input  inst0_issue,
        input  inst1_issue,
        input  ctrl0_issue,
        input  ctrl1_issue,
        input  backend_we,
        output issued_inst0,
        output issued_inst1,
        output issued_ctrl0,
        output issued_ctrl1,
        output split_stall
    );
endinterface

// File: rtl/issue_split.sv
// Dual-issue pair checker: passes independent pairs through and serializes
// dependent pairs over two backend cycles (slot 0, then slot 1).
module issue_split #(
    parameter int unsigned CTRL_W       = 16,
    parameter int unsigned REGWRITE_BIT = 0,
    parameter int unsigned RS1_USE_BIT  = 1,
    parameter int unsigned RS2_USE_BIT  = 2,
    parameter int unsigned MEM_BIT      = 3
) (
    input  logic         clock_i,
    input  logic         reset_i,
    issue_split_if.slave bus,
    output logic [31:0]  split_count_o
);

    typedef enum logic [0:0] {
        StPair,
        StSecond
    } state_e;

    state_e      state_q;
    logic [31:0] count_q;

    logic [4:0] rd0;
    logic [4:0] rd1;
    logic [4:0] rs1_1;
    logic [4:0] rs2_1;
    logic       valid0;
    logic       valid1;
    logic       raw;
    logic       waw;
    logic       structural;
    logic       hazard;

    always_comb begin
        rd0    = bus.inst0_issue[11:7];
        rd1    = bus.inst1_issue[11:7];
        rs1_1  = bus.inst1_issue[19:15];
        rs2_1  = bus.inst1_issue[24:20];
        valid0 = |bus.ctrl0_issue;
        valid1 = |bus.ctrl1_issue;

        raw = bus.ctrl0_issue[REGWRITE_BIT] && (rd0 != 5'd0) &&
              ((bus.ctrl1_issue[RS1_USE_BIT] && (rs1_1 == rd0)) ||
               (bus.ctrl1_issue[RS2_USE_BIT] && (rs2_1 == rd0)));
        waw = bus.ctrl0_issue[REGWRITE_BIT] && bus.ctrl1_issue[REGWRITE_BIT] &&
              (rd0 == rd1) && (rd0 != 5'd0);
        structural = bus.ctrl0_issue[MEM_BIT] && bus.ctrl1_issue[MEM_BIT];

        hazard = valid0 && valid1 && (raw || waw || structural);
    end

    // Outputs are zero-latency; the pipeline registers them downstream.
    always_comb begin
        bus.issued_inst0 = bus.inst0_issue;
        bus.issued_inst1 = bus.inst1_issue;
        bus.issued_ctrl0 = bus.ctrl0_issue;
        bus.issued_ctrl1 = bus.ctrl1_issue;
        bus.split_stall  = 1'b0;
        unique case (state_q)
            StPair: begin
                if (hazard) begin
                    bus.issued_inst1 = '0;
                    bus.issued_ctrl1 = '0;
                    bus.split_stall  = 1'b1;
                end
            end
            StSecond: begin
                bus.issued_inst0 = '0;
                bus.issued_ctrl0 = '0;
            end
            default: begin
                bus.issued_inst0 = '0;
                bus.issued_inst1 = '0;
                bus.issued_ctrl0 = '0;
                bus.issued_ctrl1 = '0;
            end
        endcase
    end

    // A frozen backend holds both state and counter.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= StPair;
            count_q <= '0;
        end else if (bus.backend_we) begin
            unique case (state_q)
                StPair: begin
                    if (hazard) begin
                        state_q <= StSecond;
                    end
                end
                StSecond: begin
                    state_q <= StPair;
                    count_q <= count_q + 32'd1;
                end
                default: state_q <= StPair;
            endcase
        end
    end

    assign split_count_o = count_q;

endmodule

// File: tb/tb_issue_split.sv
// Bench for issue_split: directed scenarios followed by random pairs, all checked
// against a pair/split model evaluated from the hazard rules.
module tb_issue_split;

    localparam int unsigned CTRL_W = 16;
    localparam logic [15:0] C_REGW = 16'h0001;
    localparam logic [15:0] C_RS1  = 16'h0002;
    localparam logic [15:0] C_RS2  = 16'h0004;
    localparam logic [15:0] C_MEM  = 16'h0008;

    logic        clock;
    logic        reset;
    logic [31:0] split_count;

    issue_split_if #(.CTRL_W(CTRL_W)) bus ();

    issue_split #(
        .CTRL_W      (CTRL_W),
        .REGWRITE_BIT(0),
        .RS1_USE_BIT (1),
        .RS2_USE_BIT (2),
        .MEM_BIT     (3)
    ) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .bus          (bus),
        .split_count_o(split_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    bit          m_second;
    int unsigned m_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hazard(input logic [31:0] i0, input logic [31:0] i1,
                                        input logic [15:0] c0, input logic [15:0] c1);
        int d0, d1, s1, s2;
        bit raw, waw, mem;
        d0  = int'(i0[11:7]);
        d1  = int'(i1[11:7]);
        s1  = int'(i1[19:15]);
        s2  = int'(i1[24:20]);
        raw = (c0 & C_REGW) != 0 && d0 != 0 &&
              (((c1 & C_RS1) != 0 && s1 == d0) || ((c1 & C_RS2) != 0 && s2 == d0));
        waw = (c0 & C_REGW) != 0 && (c1 & C_REGW) != 0 && d0 == d1 && d0 != 0;
        mem = (c0 & C_MEM) != 0 && (c1 & C_MEM) != 0;
        return c0 != 0 && c1 != 0 && (raw || waw || mem);
    endfunction

    // One backend cycle: drive, compare mid-cycle, clock, advance the model.
    task automatic cycle(input logic [31:0] i0, input logic [31:0] i1, input logic [15:0] c0,
                         input logic [15:0] c1, input logic we, input logic rst);
        logic [31:0] e_i0, e_i1;
        logic [15:0] e_c0, e_c1;
        bit          hz;
        logic        e_stall;
        bus.inst0_issue = i0;
        bus.inst1_issue = i1;
        bus.ctrl0_issue = c0;
        bus.ctrl1_issue = c1;
        bus.backend_we  = we;
        reset           = rst;
        hz = model_hazard(i0, i1, c0, c1);
        if (m_second) begin
            e_i0 = '0; e_c0 = '0; e_i1 = i1; e_c1 = c1; e_stall = 1'b0;
        end else if (hz) begin
            e_i0 = i0; e_c0 = c0; e_i1 = '0; e_c1 = '0; e_stall = 1'b1;
        end else begin
            e_i0 = i0; e_c0 = c0; e_i1 = i1; e_c1 = c1; e_stall = 1'b0;
        end
        @(negedge clock);
        check("issued_inst0", bus.issued_inst0, e_i0);
        check("issued_inst1", bus.issued_inst1, e_i1);
        check("issued_ctrl0", {16'd0, bus.issued_ctrl0}, {16'd0, e_c0});
        check("issued_ctrl1", {16'd0, bus.issued_ctrl1}, {16'd0, e_c1});
        check("split_stall", {31'd0, bus.split_stall}, {31'd0, e_stall});
        check("split_count", split_count, m_count);
        @(posedge clock);
        if (rst) begin
            m_second = 1'b0;
            m_count  = 0;
        end else if (we) begin
            if (m_second) begin
                m_second = 1'b0;
                m_count  = m_count + 1;
            end else if (hz) begin
                m_second = 1'b1;
            end
        end
        #1;
    endtask

    logic [31:0] ri0, ri1;
    logic [15:0] rc0, rc1;

    initial begin
        m_second = 1'b0;
        m_count  = 0;
        bus.inst0_issue = '0;
        bus.inst1_issue = '0;
        bus.ctrl0_issue = '0;
        bus.ctrl1_issue = '0;
        bus.backend_we  = 1'b0;
        reset           = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check("reset_count", split_count, 32'd0);

        // Independent pair: dual issue.
        cycle(32'h00100293, 32'h00200313, C_REGW | C_RS1, C_REGW | C_RS1, 1'b1, 1'b0);
        check("indep_count", split_count, 32'd0);

        // RAW pair: slot 0 then slot 1.
        cycle(32'h00100293, 32'h00528333, C_REGW | C_RS1, C_REGW | C_RS1 | C_RS2, 1'b1, 1'b0);
        cycle(32'h00100293, 32'h00528333, C_REGW | C_RS1, C_REGW | C_RS1 | C_RS2, 1'b1, 1'b0);
        check("raw_count", split_count, 32'd1);

        // x0 destination is never a hazard.
        cycle(32'h00100013, 32'h00000333, C_REGW | C_RS1, C_REGW | C_RS1 | C_RS2, 1'b1, 1'b0);

        // Two independent loads collide on the memory port.
        for (int k = 0; k < 2; k++)
            cycle(32'h0000A283, 32'h00412303, C_REGW | C_RS1 | C_MEM, C_REGW | C_RS1 | C_MEM,
                  1'b1, 1'b0);
        check("mem_count", split_count, 32'd2);

        // Frozen backend in both states.
        for (int k = 0; k < 3; k++)
            cycle(32'h00100293, 32'h00528333, C_REGW | C_RS1, C_REGW | C_RS1 | C_RS2, 1'b0, 1'b0);
        cycle(32'h00100293, 32'h00528333, C_REGW | C_RS1, C_REGW | C_RS1 | C_RS2, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++)
            cycle(32'h00100293, 32'h00528333, C_REGW | C_RS1, C_REGW | C_RS1 | C_RS2, 1'b0, 1'b0);
        cycle(32'h00100293, 32'h00528333, C_REGW | C_RS1, C_REGW | C_RS1 | C_RS2, 1'b1, 1'b0);
        check("freeze_count", split_count, 32'd3);

        // Build up to five splits, enter SECOND, then reset.
        for (int k = 0; k < 4; k++)
            cycle(32'h00100293, 32'h00528333, C_REGW | C_RS1, C_REGW | C_RS1 | C_RS2, 1'b1, 1'b0);
        check("five_count", split_count, 32'd5);
        cycle(32'h00100293, 32'h00528333, C_REGW | C_RS1, C_REGW | C_RS1 | C_RS2, 1'b1, 1'b0);
        cycle(32'h00100293, 32'h00528333, C_REGW | C_RS1, C_REGW | C_RS1 | C_RS2, 1'b1, 1'b1);
        check("reset_second_count", split_count, 32'd0);
        cycle(32'h00100293, 32'h00200313, C_REGW | C_RS1, C_REGW | C_RS1, 1'b1, 1'b0);

        // Random pairs with narrow register fields so hazards are common.
        for (int n = 0; n < 400; n++) begin
            ri0 = $urandom;
            ri1 = $urandom;
            ri0[11:7]  = 5'($urandom_range(0, 3));
            ri1[11:7]  = 5'($urandom_range(0, 3));
            ri1[19:15] = 5'($urandom_range(0, 3));
            ri1[24:20] = 5'($urandom_range(0, 3));
            rc0 = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            rc1 = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            cycle(ri0, ri1, rc0, rc1, ($urandom_range(0, 3) != 0), ($urandom_range(0, 63) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
